// File: rtl/dii_packet_buffer.sv
// Store-and-forward packet buffer for 16-bit flits.
// Packets are only presented downstream once their last flit is stored.
module dii_packet_buffer #(
    parameter int BUF_SIZE = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               in_data,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [15:0]               out_data,
    output logic                      out_first,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(BUF_SIZE):0] packet_count
);

    localparam int AW = $clog2(BUF_SIZE);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL  = PW'(BUF_SIZE);
    localparam logic [AW-1:0] ONE_A = AW'(1);

    logic [15:0]   mem_data_q [BUF_SIZE];
    logic          mem_last_q [BUF_SIZE];

    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] commit_q, commit_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          open_q, open_d;
    logic          drop_q, drop_d;
    logic          ofirst_q, ofirst_d;

    logic          in_fire, out_fire;
    logic          restart, store, commit, oversize;
    logic [AW-1:0] base;
    logic [PW-1:0] partial, fill_in;

    assign in_ready     = !rst && (fill_q < FULL);
    assign out_valid    = !rst && (pcnt_q != '0);
    assign out_data     = mem_data_q[rd_q];
    assign out_last     = mem_last_q[rd_q];
    assign out_first    = ofirst_q;
    assign packet_count = pcnt_q;
    assign in_fire      = in_valid && in_ready;
    assign out_fire     = out_valid && out_ready;

    // Next-state: packet open/restart/drop bookkeeping and pointer moves
    always_comb begin
        restart  = in_fire && in_first && open_q;
        store    = in_fire && (in_first || (open_q && !drop_q));
        commit   = store && in_last;
        base     = restart ? commit_q : wr_q;
        partial  = {1'b0, wr_q - commit_q};
        fill_in  = fill_q - (restart ? partial : '0) + PW'(store);
        oversize = store && !in_last && (fill_in == FULL)
                   && (pcnt_q == '0);

        rd_d     = rd_q;
        ofirst_d = ofirst_q;
        wr_d     = wr_q;
        commit_d = commit_q;
        open_d   = open_q;
        drop_d   = drop_q;

        if (out_fire) begin
            rd_d     = rd_q + ONE_A;
            ofirst_d = mem_last_q[rd_q];
        end

        if (in_fire && in_first) begin
            open_d = 1'b1;
            drop_d = 1'b0;
        end
        if (store) begin
            wr_d = base + ONE_A;
        end
        if (commit) begin
            commit_d = base + ONE_A;
            open_d   = 1'b0;
        end
        if (in_fire && !store && in_last) begin
            open_d = 1'b0;
            drop_d = 1'b0;
        end
        // A packet that fills the whole buffer can never complete
        if (oversize) begin
            wr_d   = commit_q;
            open_d = 1'b0;
            drop_d = 1'b1;
        end

        fill_d = oversize ? '0 : fill_in - PW'(out_fire);
        pcnt_d = pcnt_q + PW'(commit) - PW'(out_fire && out_last);
    end

    // Flit storage; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (store) begin
            mem_data_q[base] <= in_data;
            mem_last_q[base] <= in_last;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= '0;
            wr_q     <= '0;
            commit_q <= '0;
            fill_q   <= '0;
            pcnt_q   <= '0;
            open_q   <= 1'b0;
            drop_q   <= 1'b0;
            ofirst_q <= 1'b1;
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            commit_q <= commit_d;
            fill_q   <= fill_d;
            pcnt_q   <= pcnt_d;
            open_q   <= open_d;
            drop_q   <= drop_d;
            ofirst_q <= ofirst_d;
        end
    end

endmodule

// File: tb/tb_dii_packet_buffer.sv
// Bench for dii_packet_buffer: directed scenarios plus random
// traffic, checked every cycle against a packet-level queue model.
module tb_dii_packet_buffer;

    localparam int BS = 16;
    localparam int PW = $clog2(BS) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   in_data;
    logic          in_first, in_last, in_valid, in_ready;
    logic [15:0]   out_data;
    logic          out_first, out_last, out_valid, out_ready;
    logic [PW-1:0] packet_count;

    dii_packet_buffer #(.BUF_SIZE(BS)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_first(in_first),
        .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data), .out_first(out_first),
        .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready),
        .packet_count(packet_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        f;
        logic        l;
    } flit_t;

    int    checks   = 0;
    int    failures = 0;
    int    maxpc    = 0;
    flit_t cq[$];
    flit_t pq[$];
    bit    m_open   = 0;
    bit    m_drop   = 0;
    int    emitted[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_in(input logic [15:0] dat, input logic fi,
                            input logic la);
        bit st;
        st = 0;
        if (fi) begin
            pq.delete();
            m_open = 1;
            m_drop = 0;
            st = 1;
        end else if (m_open && !m_drop) begin
            st = 1;
        end else if (la) begin
            m_open = 0;
            m_drop = 0;
        end
        if (st) begin
            pq.push_back('{d: dat, f: fi, l: la});
            if (la) begin
                foreach (pq[i]) cq.push_back(pq[i]);
                pq.delete();
                m_open = 0;
            end else if (cq.size() == 0 && pq.size() == BS) begin
                pq.delete();
                m_open = 0;
                m_drop = 1;
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] dat,
                       input logic fi, input logic la,
                       input logic ordy, output bit acc);
        bit    eir, eov;
        int    pc;
        flit_t fl;
        in_valid = v; in_data = dat;
        in_first = fi; in_last = la;
        out_ready = ordy;
        pc = 0;
        foreach (cq[i]) if (cq[i].l) pc++;
        eir = !rst && (cq.size() + pq.size() < BS);
        eov = !rst && (pc > 0);
        @(negedge clk);
        chk("in_ready", in_ready, eir);
        chk("out_valid", out_valid, eov);
        if (!rst) begin
            chk("packet_count", packet_count, pc);
            if (int'(packet_count) > maxpc) maxpc = packet_count;
        end
        if (eov) begin
            chk("out_data", out_data, cq[0].d);
            chk("out_first", out_first, cq[0].f);
            chk("out_last", out_last, cq[0].l);
        end
        acc = v && eir;
        if (rst) begin
            cq.delete(); pq.delete();
            m_open = 0; m_drop = 0;
        end else begin
            if (eov && ordy) begin
                fl = cq.pop_front();
                emitted.push_back(int'(fl.d));
            end
            if (acc) model_in(dat, fi, la);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] dat, input logic fi,
                        input logic la, input logic ordy);
        bit a;
        a = 0;
        for (int k = 0; k < 64 && !a; k++) cyc(1, dat, fi, la, ordy, a);
        chk("send_accept", a, 1);
    endtask

    task automatic drain(input int n);
        bit a;
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 1, a);
    endtask

    initial begin
        bit a;
        int pk;
        rst = 1; in_valid = 0; in_data = 0;
        in_first = 0; in_last = 0; out_ready = 0;
        cyc(0, 0, 0, 0, 0, a);
        cyc(0, 0, 0, 0, 0, a);
        rst = 0;
        cyc(0, 0, 0, 0, 1, a);
        chk("rst_pcount", packet_count, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_iready", in_ready, 1);

        // 3-flit packet, cut-through forbidden
        emitted.delete();
        send(16'hA001, 1, 0, 1);
        send(16'hA002, 0, 0, 1);
        send(16'hA003, 0, 1, 1);
        drain(4);
        chk("p3_count", emitted.size(), 3);
        if (emitted.size() == 3) begin
            chk("p3_d0", emitted[0], 32'hA001);
            chk("p3_d1", emitted[1], 32'hA002);
            chk("p3_d2", emitted[2], 32'hA003);
        end

        // Fill completely with four 4-flit packets
        emitted.delete();
        for (int i = 0; i < 16; i++)
            send(16'h3000 + 16'(i), (i % 4) == 0, (i % 4) == 3, 0);
        cyc(0, 0, 0, 0, 0, a);
        chk("full_iready", in_ready, 0);
        chk("full_pcount", packet_count, 4);
        drain(20);
        chk("full_count", emitted.size(), 16);
        if (emitted.size() == 16)
            for (int i = 0; i < 16; i++)
                chk("full_data", emitted[i], 32'h3000 + i);

        // Restart replaces an incomplete packet
        emitted.delete();
        maxpc = 0;
        send(16'h0001, 1, 0, 1);
        send(16'h0002, 0, 0, 1);
        send(16'h0010, 1, 1, 1);
        drain(3);
        chk("rs_count", emitted.size(), 1);
        if (emitted.size() == 1) chk("rs_d0", emitted[0], 32'h0010);
        chk("rs_maxpc", maxpc, 1);

        // Oversize packet is dropped
        emitted.delete();
        for (int i = 0; i < 20; i++)
            send(16'h7000 + 16'(i), i == 0, i == 19, 1);
        send(16'hBEEF, 1, 0, 1);
        send(16'hCAFE, 0, 1, 1);
        drain(4);
        chk("ov_count", emitted.size(), 2);
        if (emitted.size() == 2) begin
            chk("ov_d0", emitted[0], 32'hBEEF);
            chk("ov_d1", emitted[1], 32'hCAFE);
        end

        // Flits without a first are ignored
        emitted.delete();
        send(16'h1111, 0, 0, 1);
        send(16'h2222, 0, 1, 1);
        drain(3);
        chk("nf_count", emitted.size(), 0);
        chk("nf_pcount", packet_count, 0);

        // Reset in the middle of a packet
        emitted.delete();
        send(16'h6001, 1, 0, 1);
        send(16'h6002, 0, 0, 1);
        rst = 1;
        cyc(0, 0, 0, 0, 1, a);
        rst = 0;
        cyc(0, 0, 0, 0, 1, a);
        chk("mr_ovalid", out_valid, 0);
        chk("mr_pcount", packet_count, 0);
        send(16'h5A5A, 1, 1, 1);
        drain(3);
        chk("mr_count", emitted.size(), 1);
        if (emitted.size() == 1) chk("mr_d0", emitted[0], 32'h5A5A);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            pk = (i / 500) % 2;
            rst = ($urandom_range(0, 599) == 0);
            cyc($urandom_range(0, 3) != 0,
                16'($urandom),
                $urandom_range(0, 7) == 0,
                $urandom_range(0, pk ? 30 : 4) == 0,
                $urandom_range(0, pk ? 1 : 4) != 0, a);
        end
        rst = 0;
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
